// File: rtl/bus_slave_responder_pkg.sv
// Shared definitions for the bus slave responder: FSM state encoding,
// request mode values and the device-select width helper.
package bus_slave_responder_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WAIT  = 3'd1,
    ST_WRITE = 3'd2,
    ST_READ  = 3'd3,
    ST_RESP  = 3'd4
  } state_e;

  localparam logic MODE_READ  = 1'b0;
  localparam logic MODE_WRITE = 1'b1;

  // Wide enough for any practical RD_CYCLES setting.
  localparam int RD_CNT_W = 8;

  function automatic int dev_sel_width(input int addr_w, input int mem_addr_w);
    return addr_w - mem_addr_w;
  endfunction

endpackage

// File: rtl/bus_slave_responder.sv
// Slave-side responder: accepts one bus request, decodes the device select,
// performs a write or read on the external BRAM and returns a done pulse.
module bus_slave_responder
  import bus_slave_responder_pkg::*;
#(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 8,
  parameter int MEM_ADDR_WIDTH = 13,
  parameter logic [ADDR_WIDTH-MEM_ADDR_WIDTH-1:0] DEV_SEL = 3'b010,
  parameter int WAIT_STATES    = 0,
  parameter int RD_CYCLES      = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      s_valid,
  input  logic                      s_mode,
  input  logic [ADDR_WIDTH-1:0]     s_addr,
  input  logic [DATA_WIDTH-1:0]     s_wdata,
  output logic                      s_ready,
  output logic                      s_done,
  output logic                      s_err,
  output logic [DATA_WIDTH-1:0]     s_rdata,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]     mem_wdata,
  output logic                      mem_wen,
  input  logic [DATA_WIDTH-1:0]     mem_rdata
);

  localparam int DSW = dev_sel_width(ADDR_WIDTH, MEM_ADDR_WIDTH);

  state_e                      state_q,     state_d;
  logic                        mode_q,      mode_d;
  logic [3:0]                  wait_cnt_q,  wait_cnt_d;
  logic [RD_CNT_W-1:0]         rd_cnt_q,    rd_cnt_d;
  logic                        s_ready_q,   s_ready_d;
  logic                        s_done_q,    s_done_d;
  logic                        s_err_q,     s_err_d;
  logic [DATA_WIDTH-1:0]       s_rdata_q,   s_rdata_d;
  logic [MEM_ADDR_WIDTH-1:0]   mem_addr_q,  mem_addr_d;
  logic [DATA_WIDTH-1:0]       mem_wdata_q, mem_wdata_d;
  logic                        mem_wen_q,   mem_wen_d;

  logic           accept;
  logic [DSW-1:0] dev_field;
  logic           start_access;
  logic           access_mode;

  assign accept    = s_valid & s_ready_q & (state_q == ST_IDLE);
  assign dev_field = s_addr[ADDR_WIDTH-1:MEM_ADDR_WIDTH];

  always_comb begin
    // NOTE: every _d gets a default before the case so no path leaves it unassigned (no latches).
    state_d      = state_q;
    mode_d       = mode_q;
    wait_cnt_d   = wait_cnt_q;
    rd_cnt_d     = rd_cnt_q;
    s_ready_d    = s_ready_q;
    s_done_d     = 1'b0;
    s_err_d      = s_err_q;
    s_rdata_d    = s_rdata_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_wen_d    = 1'b0;
    start_access = 1'b0;
    access_mode  = MODE_READ;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          mode_d      = s_mode;
          mem_addr_d  = s_addr[MEM_ADDR_WIDTH-1:0];
          mem_wdata_d = s_wdata;
          s_ready_d   = 1'b0;
          if (dev_field != DEV_SEL) begin
            // Decode miss: answer straight away, never touch the memory.
            state_d   = ST_RESP;
            s_done_d  = 1'b1;
            s_err_d   = 1'b1;
            s_rdata_d = '0;
          end else if (WAIT_STATES > 0) begin
            state_d    = ST_WAIT;
            wait_cnt_d = 4'(WAIT_STATES - 1);
          end else begin
            start_access = 1'b1;
            access_mode  = s_mode;
          end
        end
      end

      ST_WAIT: begin
        if (wait_cnt_q == 4'd0) begin
          start_access = 1'b1;
          access_mode  = mode_q;
        end else begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end
      end

      ST_WRITE: begin
        state_d  = ST_RESP;
        s_done_d = 1'b1;
        s_err_d  = 1'b0;
      end

      ST_READ: begin
        if (rd_cnt_q == '0) begin
          state_d   = ST_RESP;
          s_done_d  = 1'b1;
          s_err_d   = 1'b0;
          s_rdata_d = mem_rdata;
        end else begin
          rd_cnt_d = rd_cnt_q - RD_CNT_W'(1);
        end
      end

      ST_RESP: begin
        state_d   = ST_IDLE;
        s_ready_d = 1'b1;
      end

      default: begin
        state_d   = ST_IDLE;
        s_ready_d = 1'b1;
      end
    endcase

    // Shared entry into the memory access, reached from IDLE or after WAIT.
    if (start_access) begin
      if (access_mode == MODE_WRITE) begin
        state_d   = ST_WRITE;
        mem_wen_d = 1'b1;
      end else begin
        state_d  = ST_READ;
        rd_cnt_d = RD_CNT_W'(RD_CYCLES - 1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      mode_q      <= MODE_READ;
      wait_cnt_q  <= 4'd0;
      rd_cnt_q    <= '0;
      s_ready_q   <= 1'b1;
      s_done_q    <= 1'b0;
      s_err_q     <= 1'b0;
      s_rdata_q   <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wen_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      wait_cnt_q  <= wait_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      s_ready_q   <= s_ready_d;
      s_done_q    <= s_done_d;
      s_err_q     <= s_err_d;
      s_rdata_q   <= s_rdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wen_q   <= mem_wen_d;
    end
  end

  assign s_ready   = s_ready_q;
  assign s_done    = s_done_q;
  assign s_err     = s_err_q;
  assign s_rdata   = s_rdata_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wen   = mem_wen_q;

endmodule

// File: doc/bus_slave_responder.md
Name: bus_slave_responder

Overview:
- Slave-side end of the system-bus request/response handshake that the demo master driver initiates.
- Accepts one request at a time, decodes its device-select field and performs a write or read on a local single-port BRAM.
- Optionally inserts programmable wait states, then returns a one-cycle completion pulse with read data and an error flag.
- Sits between the bus top's slave port and the slave memory; it is the responder counterpart of the master driver FSM.

Parameters:
- ADDR_WIDTH, 16, width of the bus address.
- DATA_WIDTH, 8, width of the data bus.
- MEM_ADDR_WIDTH, 13, local memory address width; the low bits of the bus address.
- DEV_SEL, 3'b010, required value of address bits [ADDR_WIDTH-1:MEM_ADDR_WIDTH].
- WAIT_STATES, 0, extra cycles inserted before the memory access (0..15).
- RD_CYCLES, 2, cycles the READ state holds before mem_rdata is sampled (>=1).

Ports:
- clk  in  1  single clock, all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- s_valid  in  1  request present; held high by the requester until accepted.
- s_mode  in  1  request type: 0 = read, 1 = write; qualified by s_valid.
- s_addr  in  ADDR_WIDTH  request address.
- s_wdata  in  DATA_WIDTH  write data.
- s_ready  out  1  responder idle; a request is accepted on an edge where s_valid & s_ready.
- s_done  out  1  one-cycle completion pulse.
- s_err  out  1  decode error; valid when s_done is high.
- s_rdata  out  DATA_WIDTH  read data; valid when s_done is high, held until the next completion.
- mem_addr  out  MEM_ADDR_WIDTH  local memory address.
- mem_wdata  out  DATA_WIDTH  local memory write data.
- mem_wen  out  1  local memory write enable.
- mem_rdata  in  DATA_WIDTH  local memory read data.

Behaviour:
- All outputs are registered.
- Reset (async, immediate): state IDLE; s_ready=1; s_done=0; s_err=0; s_rdata=0; mem_wen=0; mem_addr=0; mem_wdata=0; wait counter and read counter=0.
- States: IDLE, WAIT, WRITE, READ, RESP.
- IDLE, accept at edge k (s_valid & s_ready):
  - Latch mode, the low MEM_ADDR_WIDTH address bits into mem_addr, and s_wdata into mem_wdata.
  - s_ready drops to 0 from cycle k+1.
  - If the top address bits differ from DEV_SEL, go to RESP with err set and no memory access.
  - Otherwise go to WAIT if WAIT_STATES>0, else to WRITE (mode=1) or READ (mode=0).
- WAIT: held exactly WAIT_STATES cycles using a 4-bit down-counter, then go to WRITE or READ.
- WRITE: one cycle with mem_wen=1; mem_wen is cleared on exit; then go to RESP.
- READ: held exactly RD_CYCLES cycles with mem_wen=0. mem_rdata is sampled into s_rdata at the edge ending the last READ cycle; then go to RESP.
- RESP: one cycle with s_done=1 and s_err valid; then go to IDLE, with s_ready=1 in the following cycle.
  - On a decode error, s_rdata is forced to 0.
  - On a successful write, s_rdata holds its previous value.
- Latencies with k = accept edge, cycles numbered from k+1:
  - Write: s_done in cycle k+2+WAIT_STATES.
  - Read: s_done in cycle k+2+WAIT_STATES+RD_CYCLES-1.
  - Decode error: s_done in cycle k+1.
  - s_ready returns in the cycle after s_done.
- s_valid while s_ready=0 is ignored. Inputs are sampled only at the accept edge; changes after acceptance have no effect.
- Back-to-back: if s_valid is held high, the next request is accepted on the first edge on which s_ready=1. The minimum spacing for writes is 3 cycles.
- Reset asserted mid-operation aborts the transfer. mem_wen falls immediately, no s_done is issued and the partial transfer is not retried.
- At most one outstanding request; no pipelining.

Decomposition:
- Shared package:
  - state encoding localparams (IDLE=3'd0, WAIT=3'd1, WRITE=3'd2, READ=3'd3, RESP=3'd4);
  - MODE_READ=0 and MODE_WRITE=1;
  - device-select width helper, ADDR_WIDTH-MEM_ADDR_WIDTH.
- No sub-module is needed inside the block. The BRAM stays external, as a separate instance in the slave top, mirroring the master-side memory.

Test Plan:
- Config for all scenarios: ADDR_WIDTH=16, MEM_ADDR_WIDTH=13, DEV_SEL=3'b010.
- WAIT_STATES=0, RD_CYCLES=2; write 0x4001 with data 0xA5 accepted at edge k -> mem_wen=1, mem_addr=0x0001, mem_wdata=0xA5 in cycle k+1; s_done=1, s_err=0 in k+2; s_ready=1 in k+3.
- Read 0x4001 after the write, with the memory model returning 0xA5 -> mem_wen stays 0, s_done in k+3, s_rdata=0xA5, s_err=0.
- Request to 0x8001 (device select 3'b100) -> no mem_wen, s_done in k+1, s_err=1, s_rdata=0x00.
- WAIT_STATES=3: write 0x4002 with data 0x3C -> mem_wen in k+4, s_done in k+5. s_valid pulses during busy cycles are ignored: exactly one mem_wen pulse occurs.
- rst asserted mid-READ (cycle k+2), released 2 cycles later -> s_ready=1 and mem_wen=0 immediately, no s_done. A new read of 0x4001 then completes normally with 0xA5.
- s_valid held high with 4 queued writes (0x4000..0x4003) -> accepts occur at k, k+3, k+6, k+9 and memory holds all 4 values.
